uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive side of the board UART link. Samples the async uart_rx line and decodes 8N1 frames (LSB first).
//  Pushes each good byte into a small first-word-fall-through FIFO with a valid/ready output.
//  Sits between the FTDI RX pin and consumers such as command parsers or the spram buffer's data_in.
//  Flags framing errors and FIFO overruns as one-cycle pulses.
// PARAMETERS
//  CLOCKS_PER_BIT  13  sys clocks per UART bit (13 @12MHz ~921600 baud; 104 ~115200); legal >= 4
//  FIFO_DEPTH      4   byte entries in output FIFO; power of two, >= 2
// PORTS
//  clock           in   1  system clock (12MHz on dev board)
//  reset           in   1  synchronous, active-high reset
//  uart_rx         in   1  async serial input, idle high
//  data_out        out  8  byte at FIFO head; defined only while data_out_valid=1
//  data_out_valid  out  1  FIFO not empty
//  data_out_ready  in   1  consumer accepts head this cycle (pop when valid & ready)
//  framing_error   out  1  1-cycle pulse: stop bit sampled low
//  overrun         out  1  1-cycle pulse: good byte dropped because FIFO full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM=IDLE; bit counter and clock counter 0.
//   Synchronizer flops reset to 1 (line idle). Reset mid-frame abandons the frame; no byte, no pulses.
//  Input sync: 2-flop synchronizer; rx_s = uart_rx delayed 2 clocks. The FSM uses only rx_s.
//  Counter: clk_cnt counts 0..CLOCKS_PER_BIT-1 and wraps. HALF = CLOCKS_PER_BIT/2 (integer divide).
//  FSM states:
//   IDLE: rx_s==0 -> START with clk_cnt=0.
//   START: at clk_cnt==HALF, sample rx_s.
//    - If 1: glitch; -> IDLE, no output.
//    - If 0: -> DATA with clk_cnt=0, bit_idx=0.
//   DATA: at clk_cnt==CLOCKS_PER_BIT-1, shift rx_s into shreg[bit_idx] (LSB first).
//    - After bit_idx 7 -> STOP with clk_cnt=0.
//    - Each data sample is thus exactly CLOCKS_PER_BIT after the previous mid-bit sample.
//   STOP: at clk_cnt==CLOCKS_PER_BIT-1, sample rx_s.
//    - If 1: push shreg; -> IDLE.
//    - If 0: framing_error=1 for this cycle; byte discarded; -> BREAK.
//   BREAK: wait for rx_s==1 -> IDLE. A held-low line yields exactly one framing_error, not repeated frames.
//  IDLE is re-entered at the stop-bit mid-point, so back-to-back frames with one stop bit are received.
//  Latency: uart_rx stop-bit mid-point +2 (sync) -> push cycle; data_out_valid rises the clock after push.
//  FIFO: FWFT; data_out = mem[rd_ptr]. Pointers have log2(FIFO_DEPTH)+1 bits, wrap naturally.
//   full = MSB differ & rest equal; empty = pointers equal.
//   - push & !full: write and advance wr_ptr.
//   - push & full & pop (same cycle): both happen; no overrun.
//   - push & full & !pop: byte dropped; overrun=1 this cycle; FIFO contents unchanged.
//   - pop when empty is ignored (valid=0).
//   - push & pop when empty: byte appears next cycle; count ends at 1.
//  framing_error and overrun are never asserted in the same cycle as each other's cause; both are registered.
// TESTING (CLOCKS_PER_BIT=13, FIFO_DEPTH=4, data_out_ready=1 unless stated)
//  1 Send 0xA5 at 13 clk/bit -> one valid cycle, data_out=0xA5; framing_error=0, overrun=0.
//  2 Send 0x00,0xFF,0x3C back-to-back, single stop bits -> three pops 0x00,0xFF,0x3C in order.
//  3 Pulse uart_rx low for 4 clocks -> no valid, no framing_error; FSM back in IDLE; next 0x55 received intact.
//  4 Send 0x81 with stop bit low, then hold line low 100 clocks -> one framing_error pulse, no byte.
//    Release the line, send 0x42 -> 0x42 received.
//  5 ready=0; send 0x01..0x05 -> after frame 5 exactly one overrun pulse; ready=1 pops 0x01..0x04 only.
//  6 Assert reset at bit 3 of 0x77, release, then send 0x12 -> no output for 0x77; 0x12 received.
//    Also sweep +/-3% baud error on 0xA5 -> still correct.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
    parameter int CLOCKS_PER_BIT = 13,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;

    // Flops preset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            push          <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            push          <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt        <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            push  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= S_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && data_out_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            overrun <= push && full && !pop;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    assign data_out_valid = !empty;
    assign data_out       = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule
